// File: rtl/animated_pattern_generator.sv
// VGA test pattern generator: nine patterns, frame-synchronous switching, auto-cycle, 2-cycle latency.
// Define TPG_ANIMATION_EN to build the bouncing-box logic behind pattern 8.
module animated_pattern_generator #(
    parameter int VIDEO_WIDTH  = 3,
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int CYCLE_FRAMES = 60,
    parameter int BOX_STEP     = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [3:0]             i_pattern,
    input  logic                   i_auto,
    input  logic [9:0]             i_hpos,
    input  logic [9:0]             i_vpos,
    input  logic                   i_visible,
    input  logic                   i_frame_start,
    output logic [VIDEO_WIDTH-1:0] o_red_video,
    output logic [VIDEO_WIDTH-1:0] o_grn_video,
    output logic [VIDEO_WIDTH-1:0] o_blu_video,
    output logic                   o_visible,
    output logic [3:0]             o_active_pattern
);

    localparam int BAR_W = H_VISIBLE / 8;

    logic [3:0]             r_active;
    logic [7:0]             r_frame_cnt;
    logic [3:0]             w_next_pattern;
    logic [2:0]             w_bar_idx;
    logic                   w_box_hit;

    logic [3:0]             r_s1_pattern;
    logic                   r_s1_visible;
    logic [2:0]             r_s1_bar;
    logic                   r_s1_hit;
    logic                   r_s1_check;
    logic                   r_s1_grid;
    logic                   r_s1_h4;
    logic                   r_s1_v4;
    logic [VIDEO_WIDTH-1:0] r_s1_ramp;

    logic [VIDEO_WIDTH-1:0] w_red, w_grn, w_blu;
    logic [VIDEO_WIDTH-1:0] r_red, r_grn, r_blu;
    logic                   r_visible;

    // Anything outside 1..7 (including 8) restarts the cycle at pattern 1.
    assign w_next_pattern = (r_active >= 4'd1 && r_active <= 4'd7) ? r_active + 4'd1 : 4'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active    <= 4'd0;
            r_frame_cnt <= 8'd0;
        end else if (i_frame_start) begin
            if (!i_auto) begin
                r_active    <= i_pattern;
                r_frame_cnt <= 8'd0;
            end else if (r_frame_cnt == 8'(CYCLE_FRAMES - 1)) begin
                r_active    <= w_next_pattern;
                r_frame_cnt <= 8'd0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

`ifdef TPG_ANIMATION_EN
    typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_e;

    localparam logic [10:0] X_MAX = 11'(H_VISIBLE - 32);
    localparam logic [10:0] Y_MAX = 11'(V_VISIBLE - 32);
    localparam logic [10:0] STEP  = 11'(BOX_STEP);

    logic [9:0]  r_box_x, r_box_y;
    dir_e        r_box_dx, r_box_dy;
    logic [10:0] w_x_ext, w_y_ext, w_h_ext, w_v_ext;

    assign w_x_ext = {1'b0, r_box_x};
    assign w_y_ext = {1'b0, r_box_y};
    assign w_h_ext = {1'b0, i_hpos};
    assign w_v_ext = {1'b0, i_vpos};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_box_x  <= 10'd0;
            r_box_y  <= 10'd0;
            r_box_dx <= DIR_INC;
            r_box_dy <= DIR_INC;
        end else if (i_frame_start) begin
            if (r_box_dx == DIR_INC) begin
                if (w_x_ext + STEP >= X_MAX) begin
                    r_box_x  <= X_MAX[9:0];
                    r_box_dx <= DIR_DEC;
                end else begin
                    r_box_x <= r_box_x + STEP[9:0];
                end
            end else begin
                if (w_x_ext <= STEP) begin
                    r_box_x  <= 10'd0;
                    r_box_dx <= DIR_INC;
                end else begin
                    r_box_x <= r_box_x - STEP[9:0];
                end
            end
            if (r_box_dy == DIR_INC) begin
                if (w_y_ext + STEP >= Y_MAX) begin
                    r_box_y  <= Y_MAX[9:0];
                    r_box_dy <= DIR_DEC;
                end else begin
                    r_box_y <= r_box_y + STEP[9:0];
                end
            end else begin
                if (w_y_ext <= STEP) begin
                    r_box_y  <= 10'd0;
                    r_box_dy <= DIR_INC;
                end else begin
                    r_box_y <= r_box_y - STEP[9:0];
                end
            end
        end
    end

    assign w_box_hit = (w_h_ext >= w_x_ext) && (w_h_ext <= w_x_ext + 11'd31) &&
                       (w_v_ext >= w_y_ext) && (w_v_ext <= w_y_ext + 11'd31);
`else
    logic w_unused;
    assign w_unused  = ^{i_vpos[9:6], i_vpos[3], 10'(V_VISIBLE), 5'(BOX_STEP)};
    assign w_box_hit = 1'b0;
`endif

    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (i_hpos >= 10'(k * BAR_W)) w_bar_idx = w_bar_idx + 3'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_pattern <= 4'd0;
            r_s1_visible <= 1'b0;
            r_s1_bar     <= 3'd0;
            r_s1_hit     <= 1'b0;
            r_s1_check   <= 1'b0;
            r_s1_grid    <= 1'b0;
            r_s1_h4      <= 1'b0;
            r_s1_v4      <= 1'b0;
            r_s1_ramp    <= '0;
        end else begin
            r_s1_pattern <= r_active;
            r_s1_visible <= i_visible;
            r_s1_bar     <= w_bar_idx;
            r_s1_hit     <= w_box_hit;
            r_s1_check   <= i_hpos[5] ^ i_vpos[5];
            r_s1_grid    <= (i_hpos[2:0] == 3'd0) || (i_vpos[2:0] == 3'd0);
            r_s1_h4      <= i_hpos[4];
            r_s1_v4      <= i_vpos[4];
            r_s1_ramp    <= VIDEO_WIDTH'(i_hpos >> 4);
        end
    end

    // NOTE: defaults first so every path assigns all three channels and no latch is inferred.
    always_comb begin
        w_red = '0;
        w_grn = '0;
        w_blu = '0;
        case (r_s1_pattern)
            4'd1: w_red = '1;
            4'd2: w_grn = '1;
            4'd3: w_blu = '1;
            4'd4: begin
                w_red = {VIDEO_WIDTH{~r_s1_bar[1]}};
                w_grn = {VIDEO_WIDTH{~r_s1_bar[2]}};
                w_blu = {VIDEO_WIDTH{~r_s1_bar[0]}};
            end
            4'd5: begin
                w_red = {VIDEO_WIDTH{r_s1_check}};
                w_grn = {VIDEO_WIDTH{r_s1_check}};
                w_blu = {VIDEO_WIDTH{r_s1_check}};
            end
            4'd6: begin
                w_red = {VIDEO_WIDTH{r_s1_grid}};
                w_grn = {VIDEO_WIDTH{r_s1_v4}};
                w_blu = {VIDEO_WIDTH{r_s1_h4}};
            end
            4'd7: begin
                w_red = r_s1_ramp;
                w_grn = r_s1_ramp;
                w_blu = r_s1_ramp;
            end
            4'd8: begin
                w_red = {VIDEO_WIDTH{r_s1_hit}};
                w_grn = {VIDEO_WIDTH{r_s1_hit}};
                w_blu = {VIDEO_WIDTH{r_s1_hit}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_red     <= '0;
            r_grn     <= '0;
            r_blu     <= '0;
            r_visible <= 1'b0;
        end else begin
            r_red     <= r_s1_visible ? w_red : '0;
            r_grn     <= r_s1_visible ? w_grn : '0;
            r_blu     <= r_s1_visible ? w_blu : '0;
            r_visible <= r_s1_visible;
        end
    end

    assign o_red_video      = r_red;
    assign o_grn_video      = r_grn;
    assign o_blu_video      = r_blu;
    assign o_visible        = r_visible;
    assign o_active_pattern = r_active;

endmodule

// File: tb/tb_animated_pattern_generator.sv
// Scoreboard bench for animated_pattern_generator (W=3, 640x480, CYCLE_FRAMES=2, BOX_STEP=2).
// Box checks are built when TPG_ANIMATION_EN is defined; otherwise pattern 8 must be black.
module tb_animated_pattern_generator;

    localparam int W  = 3;
    localparam int CF = 2;
    localparam int HV = 640;
    localparam int VV = 480;
    localparam int BS = 2;
    localparam logic [W-1:0] ONES = '1;

    typedef struct packed {
        logic         vis;
        logic [W-1:0] r;
        logic [W-1:0] g;
        logic [W-1:0] b;
    } pix_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   i_pattern;
    logic         i_auto;
    logic [9:0]   i_hpos, i_vpos;
    logic         i_visible, i_frame_start;
    logic [W-1:0] o_red, o_grn, o_blu;
    logic         o_visible;
    logic [3:0]   o_active;

    int checks = 0;
    int errors = 0;

    pix_t q[$];
    int   m_active, m_fc, mx, my;
    bit   mdx_right, mdy_down;

    // Colour bars as {R,G,B} bits, b0..b7.
    bit [2:0] bar_rgb [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

    animated_pattern_generator #(
        .VIDEO_WIDTH(W), .H_VISIBLE(HV), .V_VISIBLE(VV), .CYCLE_FRAMES(CF), .BOX_STEP(BS)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pattern(i_pattern), .i_auto(i_auto),
        .i_hpos(i_hpos), .i_vpos(i_vpos), .i_visible(i_visible), .i_frame_start(i_frame_start),
        .o_red_video(o_red), .o_grn_video(o_grn), .o_blu_video(o_blu),
        .o_visible(o_visible), .o_active_pattern(o_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic pix_t exp_pix(input int pat, input int h, input int v, input bit vis);
        pix_t p;
        int   b;
        p = '0;
        p.vis = vis;
        if (!vis) return p;
        case (pat)
            1: p.r = ONES;
            2: p.g = ONES;
            3: p.b = ONES;
            4: begin
                b = h / (HV / 8);
                if (b > 7) b = 7;
                p.r = bar_rgb[b][2] ? ONES : '0;
                p.g = bar_rgb[b][1] ? ONES : '0;
                p.b = bar_rgb[b][0] ? ONES : '0;
            end
            5: if (((h / 32) % 2) != ((v / 32) % 2)) begin
                p.r = ONES; p.g = ONES; p.b = ONES;
            end
            6: begin
                p.r = ((h % 8 == 0) || (v % 8 == 0)) ? ONES : '0;
                p.g = ((v / 16) % 2 == 1) ? ONES : '0;
                p.b = ((h / 16) % 2 == 1) ? ONES : '0;
            end
            7: begin
                p.r = W'((h / 16) % (1 << W));
                p.g = p.r;
                p.b = p.r;
            end
`ifdef TPG_ANIMATION_EN
            8: if (h >= mx && h <= mx + 31 && v >= my && v <= my + 31) begin
                p.r = ONES; p.g = ONES; p.b = ONES;
            end
`endif
            default: ;
        endcase
        return p;
    endfunction

    task automatic model_strobe(input int pat, input bit auto_);
        if (!auto_) begin
            m_active = pat;
            m_fc     = 0;
        end else if (m_fc == CF - 1) begin
            m_fc     = 0;
            m_active = (m_active >= 1 && m_active <= 7) ? m_active + 1 : 1;
        end else begin
            m_fc++;
        end
        if (mdx_right) begin
            if (mx + BS >= HV - 32) begin mx = HV - 32; mdx_right = 1'b0; end
            else mx += BS;
        end else begin
            if (mx <= BS) begin mx = 0; mdx_right = 1'b1; end
            else mx -= BS;
        end
        if (mdy_down) begin
            if (my + BS >= VV - 32) begin my = VV - 32; mdy_down = 1'b0; end
            else my += BS;
        end else begin
            if (my <= BS) begin my = 0; mdy_down = 1'b1; end
            else my -= BS;
        end
    endtask

    // One pixel clock: drive, record expectation, advance, compare the result due now.
    task automatic step(input int pat, input bit auto_, input int h, input int v,
                        input bit vis, input bit fs);
        pix_t got;
        i_pattern     = 4'(pat);
        i_auto        = auto_;
        i_hpos        = 10'(h);
        i_vpos        = 10'(v);
        i_visible     = vis;
        i_frame_start = fs;
        q.push_back(exp_pix(m_active, h, v, vis));
        if (fs) model_strobe(pat, auto_);
        @(posedge clk);
        #1;
        got = '{vis: o_visible, r: o_red, g: o_grn, b: o_blu};
        check("active", 32'(o_active), 32'(m_active));
        if (q.size() >= 2) check("pixel", 32'(got), 32'(q.pop_front()));
        else check("fill", 32'(got), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_red", 32'(o_red), 32'd0);
        check("rst_grn", 32'(o_grn), 32'd0);
        check("rst_blu", 32'(o_blu), 32'd0);
        check("rst_vis", 32'(o_visible), 32'd0);
        check("rst_active", 32'(o_active), 32'd0);
        q.delete();
        m_active = 0; m_fc = 0; mx = 0; my = 0;
        mdx_right = 1'b1; mdy_down = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int hl [12] = '{0, 7, 8, 16, 31, 32, 63, 64, 100, 255, 512, 639};
        int vl [12] = '{0, 8, 9, 17, 32, 33, 31, 40, 64, 479, 200, 100};
        int pl [6]  = '{5, 6, 7, 0, 9, 15};
        int n;

        rst_n = 1'b0; i_pattern = 4'd1; i_auto = 1'b0; i_hpos = 10'd100; i_vpos = 10'd100;
        i_visible = 1'b1; i_frame_start = 1'b0;
        #3;
        do_reset();

        // Before the first strobe the active pattern is still 0.
        step(1, 0, 100, 100, 1, 0);
        step(1, 0, 101, 100, 1, 0);
        step(1, 0, 0, 490, 0, 1);
        step(1, 0, 100, 100, 1, 0);
        step(1, 0, 200, 300, 1, 0);
        step(1, 0, 639, 479, 1, 0);

        // Mid-frame request for blue must not show until the next strobe.
        step(3, 0, 300, 200, 1, 0);
        step(3, 0, 301, 200, 1, 0);
        step(3, 0, 0, 490, 0, 1);
        step(3, 0, 10, 10, 1, 0);
        step(3, 0, 11, 10, 1, 0);

        // Colour bars, including the 79/80 boundary and the visible mask.
        step(4, 0, 0, 490, 0, 1);
        step(4, 0, 79, 5, 1, 0);
        step(4, 0, 80, 5, 1, 0);
        step(4, 0, 80, 5, 0, 0);
        for (int k = 0; k < 8; k++) begin
            step(4, 0, k * 80, 7, 1, 0);
            step(4, 0, k * 80 + 79, 7, 1, 0);
        end

        foreach (pl[p]) begin
            step(pl[p], 0, 0, 490, 0, 1);
            foreach (hl[i]) step(pl[p], 0, hl[i], vl[i], 1, 0);
        end

        // Auto-cycle from pattern 0, with a visible pixel between strobes.
        step(0, 0, 0, 490, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 490, 0, 1);
            step(0, 1, 5, 5, 1, 0);
        end
        // i_auto falls on the strobe cycle itself: the pattern input is loaded.
        step(5, 0, 0, 490, 0, 1);
        step(5, 0, 40, 0, 1, 0);
        step(5, 1, 0, 490, 0, 1);
        step(5, 1, 40, 0, 1, 0);

        step(8, 0, 0, 490, 0, 1);
`ifdef TPG_ANIMATION_EN
        n = 0;
        while (!(mx == HV - 32 && !mdx_right) && n < 400) begin
            step(8, 0, 0, 490, 0, 1);
            n++;
        end
        step(8, 0, 608, my, 1, 0);
        step(8, 0, 607, my, 1, 0);
        step(8, 0, 639, my + 31, 1, 0);
        step(8, 0, 608, my + 32, 1, 0);
        step(8, 0, 0, 490, 0, 1);
        step(8, 0, 606, my, 1, 0);
        step(8, 0, 605, my, 1, 0);
        step(8, 0, 637, my + 31, 1, 0);
        step(8, 0, 638, my, 1, 0);
`else
        n = 0;
`endif
        foreach (hl[i]) step(8, 0, hl[i], vl[i], 1, 0);

        // Reset in the middle of a frame.
        step(8, 0, 620, 20, 1, 0);
        do_reset();
        step(2, 0, 50, 50, 1, 0);
        step(2, 0, 0, 490, 0, 1);
        step(2, 0, 50, 50, 1, 0);
        step(2, 0, 51, 50, 1, 0);
        step(2, 0, 52, 50, 0, 0);
        step(2, 0, 0, 490, 0, 0);
        step(2, 0, 0, 490, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
